// File: rtl/core_pkg.sv
// Shared RV32I definitions: major opcodes (also used by the control decoder),
// the request class encoding and the halt word.
package core_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_I      = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_SYSTEM = 4'd8
  } instr_class_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_EMIT_HALT,
    ST_DONE,
    ST_ERROR
  } enc_state_e;

endpackage

// File: rtl/instr_packer.sv
// Combinational field packer: instruction class plus fields -> RV32I word.
// Class codes outside the defined set raise illegal_o.
module instr_packer
  import core_pkg::*;
(
  input  logic [3:0]  class_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  // Select the bit layout for the requested class.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    word_o    = '0;
    illegal_o = 1'b0;
    case (class_i)
      CLS_R:      word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OPC_OP};
      CLS_I:      word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_OP_IMM};
      CLS_LOAD:   word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_LOAD};
      CLS_JALR:   word_o = {imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_JALR};
      CLS_STORE:  word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_STORE};
      CLS_BRANCH: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], OPC_BRANCH};
      CLS_JAL:    word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
      CLS_LUI:    word_o = {imm_i[31:12], rd_i, OPC_LUI};
      CLS_SYSTEM: word_o = ECALL_WORD;
      default:    illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Streaming instruction encoder: accepts field-level requests, writes encoded
// words to consecutive instruction-memory addresses and appends an ecall after
// the last request. The final memory slot is always kept for that ecall.
module instr_stream_encoder
  import core_pkg::*;
#(
  parameter int unsigned           ADDR_W    = 10,
  parameter logic [ADDR_W-1:0]     BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              req_valid_i,
  output logic              req_ready,
  input  logic [3:0]        req_class_i,
  input  logic [4:0]        req_rd_i,
  input  logic [4:0]        req_rs1_i,
  input  logic [4:0]        req_rs2_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [6:0]        req_funct7_i,
  input  logic [31:0]       req_imm_i,
  input  logic              req_last_i,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              error
);

  // Count value at which only the ecall slot remains.
  localparam logic [ADDR_W:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  enc_state_e        state_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic [ADDR_W:0]   count_q;
  logic              done_q;
  logic              error_q;

  logic [31:0]       pk_word;
  logic              pk_illegal;

  instr_packer u_packer (
    .class_i   (req_class_i),
    .rd_i      (req_rd_i),
    .rs1_i     (req_rs1_i),
    .rs2_i     (req_rs2_i),
    .funct3_i  (req_funct3_i),
    .funct7_i  (req_funct7_i),
    .imm_i     (req_imm_i),
    .word_o    (pk_word),
    .illegal_o (pk_illegal)
  );

  // Ready depends on state only, never on req_valid_i.
  assign req_ready = (state_q == ST_ACTIVE);

  // Program FSM with registered write port, counter and status flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BASE_ADDR;
      imem_wdata_q <= '0;
      count_q      <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      imem_we_q <= 1'b0;
      if (start_i) begin
        // A write registered last cycle is already on the port and completes now.
        state_q <= ST_ACTIVE;
        count_q <= '0;
        done_q  <= 1'b0;
        error_q <= 1'b0;
      end else begin
        case (state_q)
          ST_ACTIVE: begin
            if (req_valid_i) begin
              if (pk_illegal || count_q == LAST_SLOT) begin
                state_q <= ST_ERROR;
                error_q <= 1'b1;
              end else begin
                imem_we_q    <= 1'b1;
                imem_addr_q  <= BASE_ADDR + count_q[ADDR_W-1:0];
                imem_wdata_q <= pk_word;
                count_q      <= count_q + CNT_ONE;
                if (req_last_i) state_q <= ST_EMIT_HALT;
              end
            end
          end
          ST_EMIT_HALT: begin
            imem_we_q    <= 1'b1;
            imem_addr_q  <= BASE_ADDR + count_q[ADDR_W-1:0];
            imem_wdata_q <= ECALL_WORD;
            count_q      <= count_q + CNT_ONE;
            state_q      <= ST_DONE;
          end
          ST_DONE: begin
            // Flag completion once the ecall write has been presented.
            done_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign word_count = count_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed bench for instr_stream_encoder: a default-size instance and a
// four-word instance (ADDR_W=2) for the capacity limit.
module tb_instr_stream_encoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests_run = 0;
  int fail_cnt  = 0;

  // Main instance signals
  logic        start, valid, last;
  logic [3:0]  cls;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm;
  logic        ready, we, done, err;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [10:0] wc;

  // Small instance signals
  logic        s_start, s_valid;
  logic        s_ready, s_we, s_done, s_err;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_wc;

  instr_stream_encoder #(.ADDR_W(10), .BASE_ADDR('0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .req_valid_i(valid),
    .req_ready(ready), .req_class_i(cls), .req_rd_i(rd), .req_rs1_i(rs1),
    .req_rs2_i(rs2), .req_funct3_i(f3), .req_funct7_i(f7), .req_imm_i(imm),
    .req_last_i(last), .imem_we(we), .imem_addr(addr), .imem_wdata(wdata),
    .word_count(wc), .done(done), .error(err)
  );

  instr_stream_encoder #(.ADDR_W(2), .BASE_ADDR('0)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .req_valid_i(s_valid),
    .req_ready(s_ready), .req_class_i(4'd1), .req_rd_i(5'd1), .req_rs1_i(5'd0),
    .req_rs2_i(5'd0), .req_funct3_i(3'd0), .req_funct7_i(7'd0), .req_imm_i(32'd5),
    .req_last_i(1'b0), .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
    .word_count(s_wc), .done(s_done), .error(s_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] c, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [2:0] fn3, input logic [6:0] fn7,
                         input logic [31:0] im, input logic l);
    valid = 1'b1; cls = c; rd = d; rs1 = s1; rs2 = s2; f3 = fn3; f7 = fn7; imm = im; last = l;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; last = 1'b0;
    cls = '0; rd = '0; rs1 = '0; rs2 = '0; f3 = '0; f7 = '0; imm = '0;
    s_start = 1'b0; s_valid = 1'b0;
    #12;
    // Reset state
    check("rst_ready", ready, 0);
    check("rst_we", we, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_wc", wc, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_ready", ready, 0);

    // Single I-type as last request, followed by the appended ecall
    do_start();
    check("t1_ready", ready, 1);
    set_req(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
    tick();
    valid = 1'b0; last = 1'b0;
    check("t1_we0", we, 1);
    check("t1_addr0", addr, 0);
    check("t1_word0", wdata, 32'h0050_0093);
    check("t1_wc1", wc, 1);
    check("t1_ready_off", ready, 0);
    tick();
    check("t1_we1", we, 1);
    check("t1_addr1", addr, 1);
    check("t1_ecall", wdata, 32'h0000_0073);
    check("t1_wc2", wc, 2);
    check("t1_done_early", done, 0);
    tick();
    check("t1_we_off", we, 0);
    check("t1_done", done, 1);
    check("t1_wc_final", wc, 2);

    // Start has priority over a simultaneous handshake
    start = 1'b1;
    set_req(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    tick();
    start = 1'b0; valid = 1'b0;
    check("prio_we", we, 0);
    check("prio_wc", wc, 0);
    check("prio_done_clr", done, 0);

    // Back-to-back R / STORE / BRANCH, then JAL and LUI(last)
    set_req(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
    tick();
    check("b2b_r_we", we, 1);
    check("b2b_r_addr", addr, 0);
    check("b2b_r_word", wdata, 32'h0020_81B3);
    set_req(4'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0);
    tick();
    check("b2b_st_we", we, 1);
    check("b2b_st_addr", addr, 1);
    check("b2b_st_word", wdata, 32'h0020_A423);
    set_req(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0);
    tick();
    check("b2b_br_we", we, 1);
    check("b2b_br_addr", addr, 2);
    check("b2b_br_word", wdata, 32'hFE20_8EE3);
    check("b2b_wc3", wc, 3);
    set_req(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b0);
    tick();
    check("jal_addr", addr, 3);
    check("jal_word", wdata, 32'h0080_00EF);
    set_req(4'd7, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1);
    tick();
    valid = 1'b0; last = 1'b0;
    check("lui_addr", addr, 4);
    check("lui_word", wdata, 32'h1234_52B7);
    tick();
    check("t2_ecall_addr", addr, 5);
    check("t2_ecall_word", wdata, 32'h0000_0073);
    check("t2_wc", wc, 6);
    tick();
    check("t2_done", done, 1);

    // Illegal class 12: no write, sticky error until start
    do_start();
    set_req(4'd12, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0);
    tick();
    valid = 1'b0;
    check("ill_we", we, 0);
    check("ill_err", err, 1);
    check("ill_ready", ready, 0);
    check("ill_wc", wc, 0);
    tick();
    check("ill_err_sticky", err, 1);
    do_start();
    check("ill_err_clr", err, 0);
    check("ill_ready_back", ready, 1);

    // ADDR_W=2: three words fill the non-reserved slots; the next request overflows
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_valid = 1'b1;
    tick();
    tick();
    tick();
    check("ovf_addr2", s_addr, 2);
    check("ovf_wc3", s_wc, 3);
    check("ovf_err_before", s_err, 0);
    tick();
    s_valid = 1'b0;
    check("ovf_we", s_we, 0);
    check("ovf_err", s_err, 1);
    check("ovf_wc_hold", s_wc, 3);
    check("ovf_ready", s_ready, 0);

    // Asynchronous reset while the ecall is pending
    do_start();
    set_req(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
    tick();
    valid = 1'b0; last = 1'b0;
    check("mid_we_before", we, 1);
    rst_n = 1'b0;
    #1;
    check("mid_we", we, 0);
    check("mid_addr", addr, 0);
    check("mid_wdata", wdata, 0);
    check("mid_wc", wc, 0);
    check("mid_done", done, 0);
    check("mid_ready", ready, 0);
    tick();
    check("mid_we_held", we, 0);
    rst_n = 1'b1;
    tick();
    check("mid_idle_ready", ready, 0);
    check("mid_idle_we", we, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
